// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the add_arbiter slice: operand word type,
// response-slot state encoding and a constant clog2 used to validate ID_W.
package add_arb_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bundle between NUM_REQ add clients and add_arbiter.
// Optional macro ADD_ARB_CARRY_EN adds the rsp_carry signal.
interface add_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   import add_arb_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rsp_valid;
   word_t                     rsp_sum;
   logic [ID_W-1:0]           rsp_id;
   logic                      rsp_ready;
`ifdef ADD_ARB_CARRY_EN
   logic                      rsp_carry;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_carry
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_carry
   );
`else
   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id
   );
`endif

endinterface

// File: rtl/add16.sv
// Library adder shared by the arbiter: W-bit wrap-around sum, no carry port.
module add16 #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/add_arb_rr_grant.sv
// Combinational round-robin select: first asserted req starting at rr_ptr,
// wrapping modulo NUM_REQ. Produces one-hot grant plus its encoded index.
module add_arb_rr_grant #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_any
);

   // Walk the requesters in priority order beginning at rr_ptr; first hit wins.
   always_comb begin
      int          idx;
      logic [ID_W-1:0] idx_w;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_w = ID_W'(idx);
         if (!grant_any && req[idx_w]) begin
            grant[idx_w] = 1'b1;
            grant_idx    = idx_w;
            grant_any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing a single add16 between NUM_REQ requesters,
// with one registered response slot (EMPTY/FULL). A drain and a new
// transfer may happen in the same cycle, giving one result per cycle.
// Optional macro ADD_ARB_CARRY_EN registers the carry out as rsp_carry.
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic   clk,
   input  logic   rst,
   add_arbiter_if.slave bus
);

   if (ID_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
      $error("add_arbiter: NUM_REQ must be 2..8 and ID_W must equal clog2(NUM_REQ)");
   end

   slot_state_e        state_q;
   slot_state_e        state_d;
   logic [ID_W-1:0]    rr_ptr_q;

   logic [NUM_REQ-1:0] grant_p0;
   logic [ID_W-1:0]    grant_idx_p0;
   logic               grant_any_p0;
   logic               slot_free_p0;
   logic               xfer_p0;
   word_t              a_p0;
   word_t              b_p0;
   word_t              sum_p0;

   word_t              sum_p1;
   logic [ID_W-1:0]    id_p1;

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
      return (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   add_arb_rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_grant (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant_p0),
      .grant_idx (grant_idx_p0),
      .grant_any (grant_any_p0)
   );

   // One-hot AND-OR mux of the granted requester's operands onto the adder.
   always_comb begin
      a_p0 = '0;
      b_p0 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_p0[i]) begin
            a_p0 = bus.req_a[i*DATA_W +: DATA_W];
            b_p0 = bus.req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   add16 #(
      .W (DATA_W)
   ) u_add (
      .a   (a_p0),
      .b   (b_p0),
      .sum (sum_p0)
   );

   assign slot_free_p0  = (state_q == SLOT_EMPTY) | bus.rsp_ready;
   assign bus.req_ready = rst ? '0 : (grant_p0 & {NUM_REQ{slot_free_p0}});
   assign xfer_p0       = grant_any_p0 & |(bus.req_valid & bus.req_ready);

   // Slot FSM next state: fill on transfer, empty on drain without transfer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SLOT_EMPTY: if (xfer_p0) state_d = SLOT_FULL;
         SLOT_FULL:  if (!xfer_p0 && bus.rsp_ready) state_d = SLOT_EMPTY;
         default:    state_d = SLOT_EMPTY;
      endcase
   end

   // Slot FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= SLOT_EMPTY;
      else     state_q <= state_d;
   end

   // ---- p0 -> p1: response slot and round-robin pointer ----
   // Load the slot and advance the pointer only on an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_p1   <= '0;
         id_p1    <= '0;
         rr_ptr_q <= '0;
      end else if (xfer_p0) begin
         sum_p1   <= sum_p0;
         id_p1    <= grant_idx_p0;
         rr_ptr_q <= next_ptr(grant_idx_p0);
      end
   end

   assign bus.rsp_valid = (state_q == SLOT_FULL);
   assign bus.rsp_sum   = sum_p1;
   assign bus.rsp_id    = id_p1;

`ifdef ADD_ARB_CARRY_EN
   logic carry_p0;
   logic carry_p1;

   // Wrap-around happened exactly when the truncated sum is below operand A.
   assign carry_p0 = (sum_p0 < a_p0);

   // Carry follows the same load/hold rules as the sum.
   always_ff @(posedge clk) begin
      if (rst)          carry_p1 <= 1'b0;
      else if (xfer_p0) carry_p1 <= carry_p0;
   end

   assign bus.rsp_carry = carry_p1;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with a response scoreboard queue.
module tb_add_arbiter;

   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   add_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

   add_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] sum;
      logic [1:0]  id;
`ifdef ADD_ARB_CARRY_EN
      logic        carry;
`endif
   } rsp_t;

   rsp_t        sb_q[$];
   rsp_t        cur;
   logic        exp_vld;
   logic [31:0] op_a [NR];
   logic [31:0] op_b [NR];
   int          vectors     = 0;
   int          miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < NR; i++) begin
         bus.req_a[32*i +: 32] = op_a[i];
         bus.req_b[32*i +: 32] = op_b[i];
      end
   endtask

   task automatic post_edge(input string tag, input logic xfer, input logic rrdy);
      if (xfer) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
         end else begin
            cur = sb_q.pop_front();
         end
         exp_vld = 1'b1;
      end else if (exp_vld && rrdy) begin
         exp_vld = 1'b0;
      end
      chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_vld));
      chk({tag, " rsp_sum"},   bus.rsp_sum,        cur.sum);
      chk({tag, " rsp_id"},    32'(bus.rsp_id),    32'(cur.id));
`ifdef ADD_ARB_CARRY_EN
      chk({tag, " rsp_carry"}, 32'(bus.rsp_carry), 32'(cur.carry));
`endif
   endtask

   task automatic cycle(input string tag, input logic [NR-1:0] vld, input logic rrdy,
                        input logic [NR-1:0] exp_rdy);
      int          g;
      logic [32:0] s;
      rsp_t        e;
      bus.req_valid = vld;
      bus.rsp_ready = rrdy;
      drive_ops();
      @(negedge clk);
      chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
      if (exp_rdy != '0) begin
         g     = onehot_idx(exp_rdy);
         s     = {1'b0, op_a[g]} + {1'b0, op_b[g]};
         e.sum = s[31:0];
         e.id  = 2'(g);
`ifdef ADD_ARB_CARRY_EN
         e.carry = s[32];
`endif
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      post_edge(tag, exp_rdy != '0, rrdy);
   endtask

   task automatic rst_cycle(input string tag, input logic [NR-1:0] vld);
      rst           = 1'b1;
      bus.req_valid = vld;
      bus.rsp_ready = 1'b0;
      drive_ops();
      @(negedge clk);
      chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      sb_q.delete();
      exp_vld = 1'b0;
      cur     = '0;
      post_edge(tag, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before 100000");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      exp_vld       = 1'b0;
      cur           = '0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      drive_ops();
      @(posedge clk);
      #1;
      rst_cycle("reset", 4'b1111);

      // 1: single request after reset
      op_a[0] = 32'h0000_FFFF;
      op_b[0] = 32'h0000_0001;
      cycle("t1_single", 4'b0001, 1'b1, 4'b0001);
      cycle("t1_drain",  4'b0000, 1'b1, 4'b0000);

      // 2: round robin from pointer 0
      rst_cycle("t2_reset", 4'b0000);
      for (int i = 0; i < NR; i++) begin
         op_a[i] = 32'(i);
         op_b[i] = 32'd3;
      end
      cycle("t2_rr0", 4'b1111, 1'b1, 4'b0001);
      cycle("t2_rr1", 4'b1111, 1'b1, 4'b0010);
      cycle("t2_rr2", 4'b1111, 1'b1, 4'b0100);
      cycle("t2_rr3", 4'b1111, 1'b1, 4'b1000);
      cycle("t2_rr4", 4'b1111, 1'b1, 4'b0001);

      // 3: backpressure on a full slot, then release
      cycle("t3_stall0",  4'b0110, 1'b0, 4'b0000);
      cycle("t3_stall1",  4'b0110, 1'b0, 4'b0000);
      cycle("t3_stall2",  4'b0110, 1'b0, 4'b0000);
      cycle("t3_release", 4'b0110, 1'b1, 4'b0010);
      cycle("t3_drain",   4'b0000, 1'b1, 4'b0000);

      // 4: wrap-around with carry, slot left full
      op_a[2] = 32'hFFFF_FFFF;
      op_b[2] = 32'h0000_0002;
      cycle("t4_wrap", 4'b0100, 1'b1, 4'b0100);

      // 5: reset with a pending response and requester 3 valid
      rst_cycle("t5_midrst", 4'b1000);
      cycle("t5_from0",  4'b1001, 1'b1, 4'b0001);
      cycle("t5_drain",  4'b0000, 1'b1, 4'b0000);

      // 6: zero operands from requester 2, then drain to empty
      op_a[2] = 32'h0;
      op_b[2] = 32'h0;
      cycle("t6_zero",  4'b0100, 1'b1, 4'b0100);
      cycle("t6_drain", 4'b0000, 1'b1, 4'b0000);
      cycle("t6_idle",  4'b0000, 1'b1, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
